// File: rtl/dds_pkg.sv
// Shared encodings for the DDS front-panel key controller: mode values,
// repeat FSM states and a mode decode helper.
package dds_pkg;

  localparam logic [1:0] MODE_AMP_SINE  = 2'd0;
  localparam logic [1:0] MODE_FREQ_SINE = 2'd1;
  localparam logic [1:0] MODE_AMP_TRI   = 2'd2;
  localparam logic [1:0] MODE_FREQ_TRI  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  // Odd modes steer up/down to the frequency word, even modes to amplitude.
  function automatic logic is_freq_mode(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button front end: 2-FF synchroniser, counting debouncer and a
// one-cycle press pulse. Internally everything is in pressed-high polarity.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int CNT_W        = 25
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_n,
  output logic key_level,
  output logic key_press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_q;
  logic [1:0]       fill_q;
  logic             armed_q;
  logic             level_q;
  logic             level_d_q;
  logic [CNT_W-1:0] cnt_q;

  // armed_q stays low until the key has been seen released after reset, so a
  // key held through reset never produces a press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q    <= 2'b00;
      fill_q    <= 2'b00;
      armed_q   <= 1'b0;
      level_q   <= 1'b0;
      level_d_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync_q    <= {sync_q[0], ~key_n};
      fill_q    <= {fill_q[0], 1'b1};
      level_d_q <= level_q;
      if (fill_q[1] && !sync_q[1]) begin
        armed_q <= 1'b1;
      end
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign key_level = level_q;
  assign key_press = level_q & ~level_d_q & armed_q;

endmodule

// File: rtl/dds_key_ctrl.sv
// DDS front-panel key controller: mode register, inc/dec strobes and, when
// DDS_KEY_AUTOREPEAT_EN is defined, the shared up/down auto-repeat FSM.
module dds_key_ctrl
  import dds_pkg::*;
#(
  parameter int DEBOUNCE_CYC   = 1_000_000,
  parameter int REPEAT_DLY_CYC = 25_000_000,
  parameter int REPEAT_PER_CYC = 5_000_000,
  parameter int CNT_W          = 25
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_mode_n,
  input  logic       key_up_n,
  input  logic       key_down_n,
  output logic [1:0] mode_cnt,
  output logic       key_inc,
  output logic       key_dec,
  output logic       key_busy
);

  logic mode_lvl, mode_press;
  logic up_lvl, up_press;
  logic down_lvl, down_press;
  logic inc_req, dec_req;
  logic rpt_fire, rpt_dir_up;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_mode_key (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_n(key_mode_n),
    .key_level(mode_lvl), .key_press(mode_press)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_up_key (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_n(key_up_n),
    .key_level(up_lvl), .key_press(up_press)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_down_key (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_n(key_down_n),
    .key_level(down_lvl), .key_press(down_press)
  );

  // A mode event wins the cycle; a press while the other key is held is ignored.
  assign inc_req  = up_press & ~down_lvl & ~mode_press;
  assign dec_req  = down_press & ~up_lvl & ~mode_press;
  assign key_busy = mode_lvl | up_lvl | down_lvl;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_cnt <= MODE_AMP_SINE;
      key_inc  <= 1'b0;
      key_dec  <= 1'b0;
    end else begin
      if (mode_press) begin
        mode_cnt <= mode_cnt + 2'd1;
      end
      key_inc <= inc_req | (rpt_fire & rpt_dir_up);
      key_dec <= dec_req | (rpt_fire & ~rpt_dir_up);
    end
  end

`ifdef DDS_KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY_CYC - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PER_CYC - 1);

  rpt_state_t       rpt_state, rpt_state_d;
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             dir_q, dir_d;
  logic             rpt_start, rpt_cancel;

  assign rpt_start  = inc_req | dec_req;
  assign rpt_cancel = mode_press | (up_lvl & down_lvl) | (dir_q ? ~up_lvl : ~down_lvl);
  assign rpt_dir_up = dir_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rpt_state <= ST_IDLE;
      rpt_cnt_q <= '0;
      dir_q     <= 1'b0;
    end else begin
      rpt_state <= rpt_state_d;
      rpt_cnt_q <= rpt_cnt_d;
      dir_q     <= dir_d;
    end
  end

  always_comb begin
    rpt_state_d = rpt_state;
    rpt_cnt_d   = rpt_cnt_q;
    dir_d       = dir_q;
    if (rpt_start) begin
      rpt_state_d = ST_DELAY;
      rpt_cnt_d   = '0;
      dir_d       = up_press;
    end else begin
      case (rpt_state)
        ST_IDLE: ;
        ST_DELAY: begin
          if (rpt_cancel) begin
            rpt_state_d = ST_IDLE;
            rpt_cnt_d   = '0;
          end else if (rpt_cnt_q == DLY_LAST) begin
            rpt_state_d = ST_REPEAT;
            rpt_cnt_d   = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (rpt_cancel) begin
            rpt_state_d = ST_IDLE;
            rpt_cnt_d   = '0;
          end else if (rpt_cnt_q == PER_LAST) begin
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          rpt_state_d = ST_IDLE;
          rpt_cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    rpt_fire = 1'b0;
    if (!rpt_start && !rpt_cancel) begin
      case (rpt_state)
        ST_DELAY:  rpt_fire = (rpt_cnt_q == DLY_LAST);
        ST_REPEAT: rpt_fire = (rpt_cnt_q == PER_LAST);
        default:   rpt_fire = 1'b0;
      endcase
    end
  end
`else
  logic unused_repeat_cfg;

  assign rpt_fire          = 1'b0;
  assign rpt_dir_up        = 1'b0;
  assign unused_repeat_cfg = ^{32'(REPEAT_DLY_CYC), 32'(REPEAT_PER_CYC)};
`endif

endmodule

// File: tb/tb_dds_key_ctrl.sv
// Bench for dds_key_ctrl: directed corner sequences, a table of clean presses
// and random key traffic, all checked each cycle against a behavioural model.
module tb_dds_key_ctrl;
  import dds_pkg::*;

  localparam int DEB = 8;
  localparam int DLY = 40;
  localparam int PER = 10;
`ifdef DDS_KEY_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       sys_clk    = 1'b0;
  logic       sys_rst_n  = 1'b0;
  logic       key_mode_n = 1'b1;
  logic       key_up_n   = 1'b1;
  logic       key_down_n = 1'b1;
  logic [1:0] mode_cnt;
  logic       key_inc, key_dec, key_busy;

  dds_key_ctrl #(
    .DEBOUNCE_CYC(DEB), .REPEAT_DLY_CYC(DLY), .REPEAT_PER_CYC(PER), .CNT_W(25)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_mode_n(key_mode_n),
    .key_up_n(key_up_n), .key_down_n(key_down_n), .mode_cnt(mode_cnt),
    .key_inc(key_inc), .key_dec(key_dec), .key_busy(key_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int tick_n = 0;
  int n_inc, n_dec, first_inc, first_dec;
  logic [31:0] dec_log[$];
  logic [31:0] exp_q[$];

  // ---------------- reference model ----------------
  // Keys: 0 = mode, 1 = up, 2 = down. Levels are in pressed-high polarity.
  bit         m_h1[3], m_h2[3];
  bit         m_win[3][DEB];
  int         m_wlen[3];
  bit         m_lvl[3], m_lvl_prev[3], m_armed[3];
  int         m_nsamp;
  bit         m_sess, m_dir_up;
  int         m_start;
  logic [1:0] m_mode;
  bit         m_inc, m_dec, m_busy;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @tick %0d: got %0d, expected %0d", name, tick_n, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_h1[k] = 0; m_h2[k] = 0; m_wlen[k] = 0;
      m_lvl[k] = 0; m_lvl_prev[k] = 0; m_armed[k] = 0;
    end
    m_nsamp = 0;
    m_sess = 0; m_dir_up = 0; m_start = 0;
    m_mode = 2'd0; m_inc = 0; m_dec = 0; m_busy = 0;
  endtask

  task automatic model_step();
    bit p[3], prs[3];
    bit ir, dr, cancel, all_new;
    int el;
    p[0] = ~key_mode_n; p[1] = ~key_up_n; p[2] = ~key_down_n;
    for (int k = 0; k < 3; k++) prs[k] = m_lvl[k] & ~m_lvl_prev[k] & m_armed[k];
    // strobes and mode follow from the events seen before this edge
    m_inc = 0; m_dec = 0;
    ir = prs[1] & ~m_lvl[2] & ~prs[0];
    dr = prs[2] & ~m_lvl[1] & ~prs[0];
    if (ir || dr) begin
      m_inc = ir; m_dec = dr;
      m_sess = AUTO; m_dir_up = ir; m_start = tick_n;
    end else if (m_sess) begin
      cancel = prs[0] | (m_lvl[1] & m_lvl[2]) | (m_dir_up ? ~m_lvl[1] : ~m_lvl[2]);
      if (cancel) m_sess = 0;
      else begin
        el = tick_n - m_start;
        if (el == DLY || (el > DLY && (el - DLY) % PER == 0)) begin
          if (m_dir_up) m_inc = 1; else m_dec = 1;
        end
      end
    end
    if (prs[0]) m_mode = m_mode + 2'd1;
    // debounced level: flips once the last DEB synchronised samples all disagree
    for (int k = 0; k < 3; k++) begin
      if (m_nsamp >= 2 && !m_h2[k]) m_armed[k] = 1;
      m_lvl_prev[k] = m_lvl[k];
      for (int i = 0; i < DEB - 1; i++) m_win[k][i] = m_win[k][i+1];
      m_win[k][DEB-1] = m_h2[k];
      if (m_wlen[k] < DEB) m_wlen[k]++;
      all_new = (m_wlen[k] == DEB);
      for (int i = 0; i < DEB; i++) if (m_win[k][i] == m_lvl[k]) all_new = 0;
      if (all_new) m_lvl[k] = ~m_lvl[k];
      m_h2[k] = m_h1[k];
      m_h1[k] = p[k];
    end
    m_nsamp++;
    m_busy = m_lvl[0] | m_lvl[1] | m_lvl[2];
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge sys_clk);
    tick_n++;
    model_step();
    #1;
    check("mode_cnt", int'(mode_cnt), int'(m_mode));
    check("key_inc", int'(key_inc), int'(m_inc));
    check("key_dec", int'(key_dec), int'(m_dec));
    check("key_busy", int'(key_busy), int'(m_busy));
    if (key_inc && key_dec) check("inc_dec_exclusive", 1, 0);
    if (key_inc) begin
      n_inc++;
      if (first_inc < 0) first_inc = tick_n;
    end
    if (key_dec) begin
      n_dec++;
      dec_log.push_back(tick_n);
      if (first_dec < 0) first_dec = tick_n;
    end
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    #1;
    check("rst_mode_cnt", int'(mode_cnt), 0);
    check("rst_key_inc", int'(key_inc), 0);
    check("rst_key_dec", int'(key_dec), 0);
    check("rst_key_busy", int'(key_busy), 0);
    model_reset();
    @(posedge sys_clk);
    #3 sys_rst_n = 1'b1;
  endtask

  task automatic set_key(input int k, input bit pressed);
    case (k)
      0: key_mode_n = ~pressed;
      1: key_up_n   = ~pressed;
      default: key_down_n = ~pressed;
    endcase
  endtask

  typedef struct {
    int         key;
    int         hold;
    logic [1:0] exp_mode;
    int         exp_inc;
    int         exp_dec;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int t_low;
    vecs[0] = '{0, 20, MODE_FREQ_SINE, 0, 0};
    vecs[1] = '{0, 20, MODE_AMP_TRI,   0, 0};
    vecs[2] = '{0, 20, MODE_FREQ_TRI,  0, 0};
    vecs[3] = '{0, 20, MODE_AMP_SINE,  0, 0};
    vecs[4] = '{0, 20, MODE_FREQ_SINE, 0, 0};
    vecs[5] = '{1, 25, MODE_FREQ_SINE, 1, 0};
    vecs[6] = '{2, 25, MODE_FREQ_SINE, 0, 1};
    first_inc = -1; first_dec = -1; n_inc = 0; n_dec = 0;

    // 1: reset release with keys idle
    #2;
    do_reset();
    repeat (100) tick();
    check("t1_inc_count", n_inc, 0);
    check("t1_dec_count", n_dec, 0);
    check("t1_mode", int'(mode_cnt), 0);
    check("t1_busy", int'(key_busy), 0);

    // 2: bouncing up key, then a clean hold
    n_inc = 0; first_inc = -1;
    for (int i = 0; i < 10; i++) begin
      key_up_n = i[0];
      repeat (3) tick();
    end
    key_up_n = 1'b0;
    t_low = tick_n;
    repeat (35) tick();
    check("t2_inc_count", n_inc, 1);
    check("t2_latency", first_inc - t_low, 2 + DEB + 1);
    key_up_n = 1'b1;
    repeat (20) tick();

    // 3: table of clean presses (mode wrap, then one up and one down)
    for (int v = 0; v < 7; v++) begin
      n_inc = 0; n_dec = 0;
      set_key(vecs[v].key, 1'b1);
      repeat (vecs[v].hold) tick();
      set_key(vecs[v].key, 1'b0);
      repeat (25) tick();
      check("t3_mode", int'(mode_cnt), int'(vecs[v].exp_mode));
      check("t3_inc_count", n_inc, vecs[v].exp_inc);
      check("t3_dec_count", n_dec, vecs[v].exp_dec);
    end

    // 4: held down key, auto-repeat schedule relative to the first strobe
    dec_log.delete(); n_dec = 0; first_dec = -1;
    key_down_n = 1'b0;
    for (int i = 0; i < 40 && first_dec < 0; i++) tick();
    check("t4_first_dec_seen", int'(first_dec >= 0), 1);
    if (first_dec >= 0) begin
      while (tick_n < first_dec + 99) tick();
    end
    key_down_n = 1'b1;
    repeat (40) tick();
    exp_q.delete();
    exp_q.push_back(0);
    if (AUTO) begin
      for (int o = DLY; o <= 100; o += PER) exp_q.push_back(o);
    end
    check("t4_strobe_count", dec_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < dec_log.size(); i++)
      check("t4_strobe_offset", int'(dec_log[i]) - first_dec, int'(exp_q[i]));

    // 5a: up held, then down joins -> silence while both held
    key_up_n = 1'b0;
    repeat (26) tick();
    key_down_n = 1'b0;
    n_inc = 0; n_dec = 0;
    repeat (60) tick();
    check("t5_both_inc", n_inc, 0);
    check("t5_both_dec", n_dec, 0);
    key_up_n = 1'b1; key_down_n = 1'b1;
    repeat (30) tick();

    // 5b: mode and up events in the same cycle
    n_inc = 0;
    key_mode_n = 1'b0; key_up_n = 1'b0;
    repeat (30) tick();
    check("t5_coincident_mode", int'(mode_cnt), int'(MODE_AMP_TRI));
    check("t5_coincident_inc", n_inc, 0);
    key_mode_n = 1'b1; key_up_n = 1'b1;
    repeat (30) tick();

    // 6: reset while up is repeating
    first_inc = -1;
    key_up_n = 1'b0;
    for (int i = 0; i < 40 && first_inc < 0; i++) tick();
    check("t6_first_inc_seen", int'(first_inc >= 0), 1);
    repeat (45) tick();
    do_reset();
    n_inc = 0;
    repeat (80) tick();
    check("t6_held_after_reset_inc", n_inc, 0);
    key_up_n = 1'b1;
    repeat (20) tick();
    n_inc = 0;
    key_up_n = 1'b0;
    repeat (25) tick();
    check("t6_repress_inc", n_inc, 1);
    key_up_n = 1'b1;
    repeat (25) tick();

    // random traffic against the model
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      key_mode_n = ($urandom_range(0, 3) != 0);
      key_up_n   = ($urandom_range(0, 1) != 0);
      key_down_n = ($urandom_range(0, 1) != 0);
      repeat ($urandom_range(1, 60)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
